dmem_bridge: RTL

Parametrised data-memory bridge between the ARM_Thumb core data port (DREQ/DADDR/DRW/DSIZE/DOUT/DIN) and a single-port synchronous SRAM with byte enables.

- Replaces the fixed combinational DSIZE/DADDR byte-enable decode with a sequenced access unit.
- Adds configurable wait states, an explicit ready handshake and misalignment detection.
- Steers write data into byte lanes and extracts read data with zero or sign extension.
- Supports 32- or 64-bit memory words.

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_lane_steer.sv | 58 +++++
 rtl/dmem_bridge.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the core data-port to SRAM bridge: access-size
// encodings, FSM states and the alignment rule.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ISSUE,
        ST_RESP,
        ST_ERR
    } state_t;

    // True when the access cannot be served: a misaligned halfword, word or
    // doubleword, or any doubleword on a 32-bit memory.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [2:0] addr_lo,
                                        input int         data_w);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo[1:0];
            default: bad = (data_w != 64) || (|addr_lo);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_steer.sv
// Byte-lane steering between right-aligned core data and the SRAM word:
// byte enables, write-data replication and read extraction with extension.
module dmem_lane_steer
    import dmem_pkg::*;
#(
    parameter int  DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int LB     = $clog2(NB)
) (
    input  logic [1:0]        size,
    input  logic [LB-1:0]     lane,
    input  logic              sign,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [NB-1:0]     be,
    output logic [DATA_W-1:0] wdata_rep,
    output logic [DATA_W-1:0] rdata_ext
);

    logic [7:0]        mask;
    logic [DATA_W-1:0] shifted;

    // Decode size into a lane mask, replicate write data and extract read data.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave a value unassigned and infer a latch.
        mask      = 8'h00;
        wdata_rep = wdata;
        rdata_ext = '0;
        shifted   = rdata >> {lane, 3'b000};

        case (size)
            SZ_BYTE: begin
                mask      = 8'h01;
                wdata_rep = {NB{wdata[7:0]}};
                rdata_ext = {{(DATA_W-8){sign & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                mask      = 8'h03;
                wdata_rep = {(NB/2){wdata[15:0]}};
                rdata_ext = {{(DATA_W-16){sign & shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                mask      = 8'h0F;
                wdata_rep = {(NB/4){wdata[31:0]}};
                rdata_ext = DATA_W'(shifted[31:0]);
            end
            default: begin
                mask      = 8'hFF;
                wdata_rep = wdata;
                rdata_ext = shifted;
            end
        endcase

        be = NB'(mask) << lane;
    end

endmodule

// File: rtl/dmem_bridge.sv
// Sequenced data-memory bridge: accepts one core request at a time, inserts
// optional wait states, issues a single SRAM cycle and returns a ready pulse.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int  DATA_W      = 32,
    parameter int  MEM_AW      = 12,
    parameter int  WAIT_CYCLES = 0,
    localparam int NB          = DATA_W / 8,
    localparam int LB          = $clog2(NB)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              DREQ,
    input  logic [31:0]       DADDR,
    input  logic              DRW,
    input  logic [1:0]        DSIZE,
    input  logic              DSIGN,
    input  logic [DATA_W-1:0] DOUT,
    output logic [DATA_W-1:0] DIN,
    output logic              DREADY,
    output logic              DERR,
    output logic              MCSN,
    output logic              MWE,
    output logic [MEM_AW-1:0] MADDR,
    output logic [NB-1:0]     MBE,
    output logic [DATA_W-1:0] MDI,
    input  logic [DATA_W-1:0] MDO
);

    localparam int AW = MEM_AW + LB;

    state_t            state, state_next;
    logic [2:0]        wait_cnt, wait_cnt_next;

    logic [AW-1:0]     lat_addr;
    logic              lat_rw;
    logic [1:0]        lat_size;
    logic              lat_sign;
    logic [DATA_W-1:0] lat_wdata;

    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wdata_rep;
    logic [DATA_W-1:0] rdata_ext;

    logic              accept;
    logic              unused_addr_bits;

    assign accept           = (state == ST_IDLE) && DREQ;
    assign unused_addr_bits = ^DADDR[31:AW];

    dmem_lane_steer #(.DATA_W(DATA_W)) u_steer (
        .size      (lat_size),
        .lane      (lat_addr[LB-1:0]),
        .sign      (lat_sign),
        .wdata     (lat_wdata),
        .rdata     (MDO),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    // State and wait-counter register.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RESET) begin
            state    <= ST_IDLE;
            wait_cnt <= 3'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Capture the request fields at acceptance; later core changes are ignored.
    always_ff @(posedge CLK) begin
        // NOTE: these are pure datapath holding registers, only consumed after
        // a fresh acceptance reloads them, so they carry no reset.
        if (accept) begin
            lat_addr  <= DADDR[AW-1:0];
            lat_rw    <= DRW;
            lat_size  <= DSIZE;
            lat_sign  <= DSIGN;
            lat_wdata <= DOUT;
        end
    end

    // Next-state decode and Moore outputs for the access sequence.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        DIN           = '0;
        DREADY        = 1'b0;
        DERR          = 1'b0;
        MCSN          = 1'b1;
        MWE           = 1'b0;
        MADDR         = '0;
        MBE           = '0;
        MDI           = '0;

        case (state)
            ST_IDLE: begin
                if (DREQ) begin
                    if (misaligned(DSIZE, DADDR[2:0], DATA_W)) begin
                        state_next = ST_ERR;
                    end else if (WAIT_CYCLES > 0) begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = 3'(WAIT_CYCLES - 1);
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 3'd0) begin
                    state_next = ST_ISSUE;
                end else begin
                    wait_cnt_next = wait_cnt - 3'd1;
                end
            end
            ST_ISSUE: begin
                MCSN       = 1'b0;
                MWE        = lat_rw;
                MADDR      = lat_addr[AW-1:LB];
                MBE        = be;
                MDI        = wdata_rep;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                DREADY     = 1'b1;
                DIN        = lat_rw ? '0 : rdata_ext;
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                DREADY     = 1'b1;
                DERR       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
